// File: rtl/lsu_ctrl.sv
// Load/store unit control: turns execute-stage requests into aligned
// doubleword memory accesses and returns extended load data or an error.
//
// Handshakes: a transfer happens on any rising clk edge where both valid and
// ready are high. A valid, once raised, stays high with its payload stable
// until the matching ready is seen; ready may be asserted freely. This holds
// for req_*, mem_* (request side) and resp_*. mem_rvalid is a one-cycle
// strobe without backpressure, honoured only while waiting for load data.
module lsu_ctrl #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            stateNext;
  logic              wenQ;
  logic [2:0]        func3Q;
  logic [ADDR_W-1:0] addrQ;
  logic [63:0]       wdataQ;
  logic [63:0]       respRdataQ;
  logic              respErrQ;
  logic [CNT_W-1:0]  waitCnt;

  logic              badAccess;
  logic              timeoutHit;
  logic [63:0]       laneData;
  logic [63:0]       loadData;
  logic [7:0]        baseMask;

  // Reject misaligned accesses and the illegal func3 before touching memory.
  always_comb begin
    badAccess = 1'b0;
    case (req_func3)
      3'b001, 3'b101: badAccess = req_addr[0];
      3'b010, 3'b110: badAccess = |req_addr[1:0];
      3'b011:         badAccess = |req_addr[2:0];
      3'b111:         badAccess = 1'b1;
      default:        badAccess = 1'b0;
    endcase
  end

  // Counter equals TIMEOUT-1 on the TIMEOUT-th WAIT cycle; that cycle aborts
  // unless read data arrives in it.
  always_comb begin
    timeoutHit = (TIMEOUT != 0) && (waitCnt == CNT_W'(TIMEOUT - 1));
  end

  // Move the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    laneData = mem_rdata >> {addrQ[2:0], 3'b000};
    loadData = laneData;
    case (func3Q)
      3'b000:  loadData = {{56{laneData[7]}},  laneData[7:0]};
      3'b001:  loadData = {{48{laneData[15]}}, laneData[15:0]};
      3'b010:  loadData = {{32{laneData[31]}}, laneData[31:0]};
      3'b100:  loadData = {56'd0, laneData[7:0]};
      3'b101:  loadData = {48'd0, laneData[15:0]};
      3'b110:  loadData = {32'd0, laneData[31:0]};
      default: loadData = laneData;
    endcase
  end

  // Byte-lane mask for the access size before shifting to the address lane.
  always_comb begin
    baseMask = 8'hFF;
    case (func3Q[1:0])
      2'b00:   baseMask = 8'h01;
      2'b01:   baseMask = 8'h03;
      2'b10:   baseMask = 8'h0F;
      default: baseMask = 8'hFF;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and outputs; outputs depend only on state and latched fields.
  always_comb begin
    stateNext  = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_wen    = 1'b0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    resp_valid = 1'b0;
    resp_rdata = respRdataQ;
    resp_err   = respErrQ;
    dbgState   = state;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          stateNext = badAccess ? RESP : REQ;
        end
      end
      REQ: begin
        mem_valid = 1'b1;
        mem_addr  = {addrQ[ADDR_W-1:3], 3'b000};
        mem_wen   = wenQ;
        mem_wdata = wdataQ << {addrQ[2:0], 3'b000};
        mem_wmask = baseMask << addrQ[2:0];
        if (mem_ready) begin
          stateNext = wenQ ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid || timeoutHit) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request fields, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wenQ       <= 1'b0;
      func3Q     <= 3'b000;
      addrQ      <= '0;
      wdataQ     <= '0;
      respRdataQ <= '0;
      respErrQ   <= 1'b0;
      waitCnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wenQ       <= req_wen;
            func3Q     <= req_func3;
            addrQ      <= req_addr;
            wdataQ     <= req_wdata;
            respRdataQ <= '0;
            respErrQ   <= badAccess;
          end
        end
        REQ: begin
          if (mem_ready && !wenQ) begin
            waitCnt <= '0;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt + CNT_W'(1);
          if (mem_rvalid) begin
            respRdataQ <= loadData;
            respErrQ   <= 1'b0;
          end else if (timeoutHit) begin
            respRdataQ <= '0;
            respErrQ   <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            respRdataQ <= '0;
            respErrQ   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting directly upstream of the data-memory port; receives load/store requests from the execute stage.
- Generates the 8-byte-aligned address, shifted write data and byte write mask for the DPI-backed memory.
- Extracts, sign-extends or zero-extends load data returned by the memory.
- Multi-cycle valid/ready handshakes on both sides, so memory latency can exceed one cycle.

Parameters:
- ADDR_W, 64, address width.
- TIMEOUT, 255, maximum cycles spent in WAIT before aborting with error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  LSU can accept a request
- req_wen  in  1  1=store, 0=load
- req_func3  in  3  RV64 funct3 (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 illegal)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  64  store data, right-aligned
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal func3 or timeout
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  req_addr with bits [2:0] cleared
- mem_wen  out  1  write enable
- mem_wdata  out  64  req_wdata shifted left by 8*addr[2:0]
- mem_wmask  out  8  byte lanes; base mask 0x01/0x03/0x0F/0xFF shifted left by addr[2:0]
- mem_rvalid  in  1  read data valid
- mem_rdata  in  64  aligned doubleword

Behaviour:
- Clock, reset and outputs:
  - Single clock domain.
  - rst is synchronous and active-high.
  - On rst, state is IDLE and every output is 0, except req_ready=1.
  - mem_* and resp_* outputs are registered or derived only from state and latched fields, never combinationally from req_*.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1. Accept on req_valid & req_ready; latch wen, func3, addr, wdata.
  - Misaligned access (H: addr[0]≠0; W/WU: addr[1:0]≠0; D: addr[2:0]≠0) or func3=111 → RESP with resp_err=1, resp_rdata=0, and no memory access.
  - Otherwise → REQ.
- REQ:
  - mem_valid=1; mem_* held stable until mem_ready.
  - Store and mem_ready → RESP, resp_err=0, resp_rdata=0.
  - Load and mem_ready → WAIT; clear the timeout counter.
  - mem_rvalid is ignored in REQ.
- WAIT:
  - mem_valid=0.
  - On mem_rvalid: select byte/half/word/dword at addr[2:0]; sign-extend for B/H/W, zero-extend for BU/HU/WU; register into resp_rdata → RESP.
  - Counter increments each WAIT cycle. When TIMEOUT≠0 and the counter reaches TIMEOUT without rvalid → RESP with resp_err=1, resp_rdata=0.
  - mem_rvalid arriving in the same cycle the counter reaches TIMEOUT: data wins (no error).
- RESP:
  - resp_valid=1; resp_rdata and resp_err held until resp_ready.
  - On resp_ready → IDLE; resp_valid drops next cycle.
  - No back-to-back bypass: minimum one IDLE cycle between requests.
- Latency: successful zero-wait load is 4 cycles from accept to resp_valid deassert-ready (accept, REQ, WAIT, RESP); store is 3.
- mem_rvalid outside WAIT is ignored (no state change, no data capture).
- Reset mid-operation:
  - Immediate return to IDLE; any pending response is dropped.
  - A late mem_rvalid after reset is ignored.

Test Plan:
- Reset: assert rst 2 cycles during WAIT → req_ready=1, mem_valid=0, resp_valid=0; then drive mem_rvalid=1, mem_rdata=all-ones → no resp_valid.
- Load byte: LB addr 0x80000003, mem_rdata 0x00000000_80FF0000 with mem_ready=1, rvalid the cycle after → mem_addr 0x80000000, resp_rdata 0xFFFFFFFF_FFFFFF80, resp_err=0. Repeat with LBU → 0x80.
- Store word: SW addr 0x80000004, wdata 0x12345678 → mem_wmask 0xF0, mem_wdata 0x12345678_00000000, mem_wen=1. Hold mem_ready low 3 cycles → outputs stable; then resp_valid with resp_rdata=0.
- Misaligned LD at 0x80000004 → resp_err=1 within 2 cycles, mem_valid never asserted. func3=111 → same result.
- Timeout and backpressure: TIMEOUT=4, LW with no mem_rvalid → resp_err=1 after 4 WAIT cycles. Keep resp_ready low 5 cycles → resp held. Separately, rvalid on the 4th WAIT cycle → data returned, err=0.
